multicycle_control: RTL and testbench

- Multi-cycle main control unit for the RV32I datapath. It replaces single-cycle opcode decoding with a sequencer: FETCH, DECODE, EXEC/ADDR, MEM, WB.
- Supports R-type, I-type ALU, LW, SW and BEQ. JAL/JALR are optional.
- Adds a variable-latency memory handshake with a wait timeout and a sticky fault state.
- Sits between the instruction register (IR) and the datapath muxes, PC, register file and memory port.

---
 rtl/multicycle_control_pkg.sv | 55 +++++
 rtl/multicycle_control_mem_wait_timer.sv | 19 +
 rtl/multicycle_control.sv | 118 +++++++++++
 tb/tb_multicycle_control.sv | 136 +++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared state, class, opcode and mux encodings for the RV32I multicycle control unit.
// MC_CONTROL_JUMP_EN adds the JUMP state and JAL/JALR decoding.
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    S_BOOT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
`ifdef MC_CONTROL_JUMP_EN
    S_JUMP   = 4'd8,
`endif
    S_FAULT  = 4'd9
  } state_t;
  typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_JALR} cls_t;
  localparam logic [4:0] OP_R    = 5'b01100;
  localparam logic [4:0] OP_I    = 5'b00100;
  localparam logic [4:0] OP_LW   = 5'b00000;
  localparam logic [4:0] OP_SW   = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_REG = 2'b11;
  function automatic cls_t classify(input logic [4:0] op);
    return op == OP_R   ? C_R :
           op == OP_I   ? C_I :
           op == OP_LW  ? C_LW :
           op == OP_SW  ? C_SW :
           op == OP_BEQ ? C_BEQ :
`ifdef MC_CONTROL_JUMP_EN
           op == OP_JAL  ? C_JAL :
           op == OP_JALR ? C_JALR :
`endif
           C_NONE;
  endfunction
  function automatic state_t decode_next(input cls_t c);
    return (c == C_R  || c == C_I)  ? S_EXEC :
           (c == C_LW || c == C_SW) ? S_ADDR :
           c == C_BEQ               ? S_BRANCH :
`ifdef MC_CONTROL_JUMP_EN
           (c == C_JAL || c == C_JALR) ? S_JUMP :
`endif
           S_FAULT;
  endfunction
endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts unacknowledged memory request cycles and flags expiry on the last allowed one.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);
  localparam int W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (waiting && cnt != LAST) cnt <= cnt + 1'b1;
  assign expired = (MEM_TIMEOUT > 0) && waiting && cnt == LAST;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multicycle sequencer with memory handshake timeout and sticky fault.
// MC_CONTROL_JUMP_EN enables JAL/JALR through the JUMP state.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                mem_req,
  output logic                mem_we,
  output logic                alu_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                jump_link,
  output logic                retire,
  output logic                fault,
  output logic [3:0]          state_o
);
  state_t state, next;
  cls_t cls;
  logic [1:0] aop;
  logic expired, clear;
  assign clear = next != state && (next == S_FETCH || next == S_MEM);
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .waiting(mem_req && !mem_ready),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_BOOT;
      cls <= C_NONE;
    end else begin
      state <= next;
      if (state == S_DECODE) cls <= classify(opcode[4:0]);
    end
  always_comb begin
    next = state;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = PCSRC_SEQ;
    mem_req = 1'b0;
    mem_we = 1'b0;
    alu_src = 1'b0;
    aop = ALUOP_ADD;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    jump_link = 1'b0;
    retire = 1'b0;
    fault = 1'b0;
    case (state)
      S_BOOT: next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_write = mem_ready;
        next = mem_ready ? S_DECODE : expired ? S_FAULT : S_FETCH;
      end
      S_DECODE: next = decode_next(classify(opcode[4:0]));
      S_EXEC: begin
        alu_src = cls == C_I;
        aop = cls == C_I ? ALUOP_I : ALUOP_R;
        next = S_WB;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        next = S_MEM;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we = cls == C_SW;
        pc_write = mem_ready && cls == C_SW;
        retire = mem_ready && cls == C_SW;
        next = mem_ready ? (cls == C_SW ? S_FETCH : S_WB) : expired ? S_FAULT : S_MEM;
      end
      S_WB: begin
        reg_write = 1'b1;
        mem_to_reg = cls == C_LW;
        pc_write = 1'b1;
        retire = 1'b1;
        next = S_FETCH;
      end
      S_BRANCH: begin
        aop = ALUOP_BR;
        pc_write = 1'b1;
        pc_src = branch_taken ? PCSRC_BR : PCSRC_SEQ;
        retire = 1'b1;
        next = S_FETCH;
      end
`ifdef MC_CONTROL_JUMP_EN
      S_JUMP: begin
        reg_write = 1'b1;
        jump_link = 1'b1;
        pc_write = 1'b1;
        pc_src = cls == C_JALR ? PCSRC_REG : PCSRC_JMP;
        alu_src = 1'b1;
        retire = 1'b1;
        next = S_FETCH;
      end
`endif
      S_FAULT: fault = 1'b1;
      default: next = S_FAULT;
    endcase
  end
  assign alu_op = ALUOP_W'(aop);
  assign state_o = state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; the driver queues per-cycle expectations, a negedge monitor compares them.
module tb_multicycle_control;
  import multicycle_control_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, mem_ready = 1'b0, branch_taken = 1'b0;
  logic [4:0] opcode = OP_R;
  logic ir_write, pc_write, mem_req, mem_we, alu_src, mem_to_reg, reg_write, jump_link, retire, fault;
  logic [1:0] pc_src, alu_op;
  logic [3:0] state_o;
  logic [13:0] act;
  localparam logic [13:0] IRW = 14'h2000, PCW = 14'h1000, PS_BR = 14'h0400, PS_J = 14'h0800, PS_R = 14'h0C00;
  localparam logic [13:0] MRQ = 14'h0200, MWE = 14'h0100, ASRC = 14'h0080, AO_BR = 14'h0020, AO_R = 14'h0040;
  localparam logic [13:0] AO_I = 14'h0060, M2R = 14'h0010, RW = 14'h0008, JL = 14'h0004, RET = 14'h0002, FLT = 14'h0001;
  typedef struct {
    string       nm;
    logic [3:0]  st;
    logic [13:0] o;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  multicycle_control #(.OPCODE_W(5), .ALUOP_W(2), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .jump_link(jump_link), .retire(retire), .fault(fault), .state_o(state_o)
  );
  always #5 clk = ~clk;
  assign act = {ir_write, pc_write, pc_src, mem_req, mem_we, alu_src, alu_op, mem_to_reg, reg_write, jump_link, retire, fault};
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (state_o !== e.st || act !== e.o) begin
        errors++;
        $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b", e.nm, state_o, act, e.st, e.o);
      end
    end
  task automatic cyc(input string nm, input logic mr, input logic [3:0] st, input logic [13:0] o);
    exp_t x;
    x.nm = nm;
    x.st = st;
    x.o = o;
    mem_ready = mr;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cyc("reset", 1'b1, S_BOOT, 14'h0);
    rst_n = 1'b1;
    cyc("boot", 1'b1, S_BOOT, 14'h0);
  endtask
  task automatic fetch_decode(input logic [4:0] op);
    opcode = op;
    cyc("fetch", 1'b1, S_FETCH, MRQ | IRW);
    cyc("decode", 1'b1, S_DECODE, 14'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_hold", 1'b0, S_BOOT, 14'h0);
    rst_n = 1'b1;
    cyc("boot", 1'b1, S_BOOT, 14'h0);
    fetch_decode(OP_R);
    cyc("r_exec", 1'b1, S_EXEC, AO_R);
    cyc("r_wb", 1'b1, S_WB, RW | PCW | RET);
    fetch_decode(OP_I);
    cyc("i_exec", 1'b1, S_EXEC, ASRC | AO_I);
    cyc("i_wb", 1'b1, S_WB, RW | PCW | RET);
    fetch_decode(OP_LW);
    cyc("lw_addr", 1'b1, S_ADDR, ASRC);
    repeat (3) cyc("lw_mem_wait", 1'b0, S_MEM, MRQ);
    cyc("lw_mem", 1'b1, S_MEM, MRQ);
    cyc("lw_wb", 1'b1, S_WB, RW | M2R | PCW | RET);
    fetch_decode(OP_SW);
    cyc("sw_addr", 1'b1, S_ADDR, ASRC);
    cyc("sw_mem_wait", 1'b0, S_MEM, MRQ | MWE);
    cyc("sw_mem", 1'b1, S_MEM, MRQ | MWE | PCW | RET);
    fetch_decode(OP_BEQ);
    branch_taken = 1'b1;
    cyc("beq_taken", 1'b1, S_BRANCH, AO_BR | PCW | PS_BR | RET);
    fetch_decode(OP_BEQ);
    branch_taken = 1'b0;
    cyc("beq_not_taken", 1'b1, S_BRANCH, AO_BR | PCW | RET);
    opcode = OP_R;
    repeat (15) cyc("fetch_wait", 1'b0, S_FETCH, MRQ);
    cyc("fetch_ready_at_limit", 1'b1, S_FETCH, MRQ | IRW);
    cyc("limit_decode", 1'b1, S_DECODE, 14'h0);
    cyc("limit_exec", 1'b1, S_EXEC, AO_R);
    cyc("limit_wb", 1'b1, S_WB, RW | PCW | RET);
    opcode = OP_LW;
    repeat (10) cyc("fetch_wait_pre_mem", 1'b0, S_FETCH, MRQ);
    fetch_decode(OP_LW);
    cyc("lw_addr2", 1'b1, S_ADDR, ASRC);
    repeat (16) cyc("mem_timeout_wait", 1'b0, S_MEM, MRQ);
    cyc("mem_timeout_fault", 1'b1, S_FAULT, FLT);
    do_reset();
    repeat (16) cyc("fetch_timeout_wait", 1'b0, S_FETCH, MRQ);
    repeat (2) cyc("fetch_timeout_fault", 1'b1, S_FAULT, FLT);
    do_reset();
    fetch_decode(5'b11111);
    branch_taken = 1'b1;
    repeat (3) cyc("illegal_fault", 1'b1, S_FAULT, FLT);
    branch_taken = 1'b0;
    do_reset();
    fetch_decode(OP_JALR);
`ifdef MC_CONTROL_JUMP_EN
    cyc("jalr_jump", 1'b1, S_JUMP, RW | JL | PCW | RET | PS_R | ASRC);
    fetch_decode(OP_JAL);
    cyc("jal_jump", 1'b1, S_JUMP, RW | JL | PCW | RET | PS_J | ASRC);
`else
    cyc("jalr_fault", 1'b1, S_FAULT, FLT);
    do_reset();
`endif
    fetch_decode(OP_LW);
    cyc("mid_addr", 1'b1, S_ADDR, ASRC);
    cyc("mid_mem_wait", 1'b0, S_MEM, MRQ);
    do_reset();
    cyc("fetch_after_reset", 1'b1, S_FETCH, MRQ | IRW);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
